// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares the DDR read-burst channel between the ISA fetch
// requester and the data-path operand fetch requester. Grants are round-robin
// and last one complete burst. Returned beats are steered to the current owner.
// A watchdog aborts a burst that stops delivering beats.
module ddr_rd_arbiter #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DDR_DATA_WIDTH = 32,
    parameter int ISA_WIDTH      = 30,
    parameter int LEN_WIDTH      = 10,
    parameter int TIMEOUT        = 1024
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      isa_rd_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_rd_addr,
    input  logic [LEN_WIDTH-1:0]      isa_rd_len,
    output logic [ISA_WIDTH-1:0]      isa_rd_data,
    output logic                      isa_rd_valid,
    output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
    output logic                      isa_rd_done,

    input  logic                      dat_rd_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dat_rd_addr,
    input  logic [LEN_WIDTH-1:0]      dat_rd_len,
    output logic [DDR_DATA_WIDTH-1:0] dat_rd_data,
    output logic                      dat_rd_valid,
    output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
    output logic                      dat_rd_done,

    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    input  logic                      rd_burst_data_valid,
    input  logic                      rd_burst_finish,

    output logic                      rd_err,
    output logic [1:0]                owner,
    output logic [1:0]                st_cur_arb
);

    // Watchdog is wide enough to hold TIMEOUT itself.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_ISA  = 2'b01;
    localparam logic [1:0] OWN_DAT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                owner_q, owner_d;
    logic                      lg_dat_q, lg_dat_d;   // last grant went to data side
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic                      breq_q, breq_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic [ISA_WIDTH-1:0]      isa_data_q, isa_data_d;
    logic                      isa_valid_q, isa_valid_d;
    logic [LEN_WIDTH-1:0]      isa_cnt_q, isa_cnt_d;
    logic                      isa_done_q, isa_done_d;
    logic [DDR_DATA_WIDTH-1:0] dat_data_q, dat_data_d;
    logic                      dat_valid_q, dat_valid_d;
    logic [LEN_WIDTH-1:0]      dat_cnt_q, dat_cnt_d;
    logic                      dat_done_q, dat_done_d;
    logic                      err_q, err_d;

    // Arbitration and burst-termination terms.
    logic                 any_req, pick_isa;
    logic [LEN_WIDTH-1:0] sel_len, cur_cnt, cnt_inc;
    logic                 beat, last_beat, fin, expire, abort;

    // Round robin: on contention the requester that did not win last time goes.
    assign any_req  = isa_rd_req | dat_rd_req;
    assign pick_isa = isa_rd_req & (~dat_rd_req | lg_dat_q);
    assign sel_len  = pick_isa ? isa_rd_len : dat_rd_len;

    assign cur_cnt   = (owner_q == OWN_ISA) ? isa_cnt_q : dat_cnt_q;
    assign cnt_inc   = cur_cnt + 1'b1;
    assign beat      = (state_q == BURST) & rd_burst_data_valid;
    assign last_beat = beat & (cnt_inc == len_q);
    assign fin       = (state_q == BURST) & rd_burst_finish;
    assign expire    = (state_q == BURST) & (wd_q == WD_LAST);
    // Watchdog loses to a beat or finish arriving in the same cycle.
    assign abort     = expire & ~beat & ~fin;

    // Next-state logic of the arbitration FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = (sel_len == '0) ? DONE : GRANT;
            GRANT:   state_d = BURST;
            BURST:   if (last_beat | fin | expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch request, steer beats, pulse done/err.
    always_comb begin
        owner_d     = owner_q;
        lg_dat_d    = lg_dat_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wd_d        = wd_q;
        isa_data_d  = isa_data_q;
        isa_cnt_d   = isa_cnt_q;
        dat_data_d  = dat_data_q;
        dat_cnt_d   = dat_cnt_q;
        isa_valid_d = 1'b0;
        dat_valid_d = 1'b0;
        isa_done_d  = 1'b0;
        dat_done_d  = 1'b0;
        err_d       = 1'b0;
        breq_d      = (state_d == BURST);
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick_isa ? OWN_ISA : OWN_DAT;
                    addr_d  = pick_isa ? isa_rd_addr : dat_rd_addr;
                    len_d   = sel_len;
                    wd_d    = '0;
                    if (pick_isa) isa_cnt_d = '0;
                    else          dat_cnt_d = '0;
                    // Zero-length burst never touches DDR; finish straight away.
                    if (sel_len == '0) begin
                        isa_done_d = pick_isa;
                        dat_done_d = ~pick_isa;
                    end
                end
            end
            GRANT: begin
                wd_d = wd_q + 1'b1;
            end
            BURST: begin
                if (beat) begin
                    wd_d = '0;
                    if (owner_q == OWN_ISA) begin
                        isa_data_d  = rd_burst_data[ISA_WIDTH-1:0];
                        isa_valid_d = 1'b1;
                        isa_cnt_d   = cnt_inc;
                    end else begin
                        dat_data_d  = rd_burst_data;
                        dat_valid_d = 1'b1;
                        dat_cnt_d   = cnt_inc;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                if (state_d == DONE) begin
                    isa_done_d = (owner_q == OWN_ISA);
                    dat_done_d = (owner_q == OWN_DAT);
                    err_d      = abort;
                end
            end
            DONE: begin
                lg_dat_d = (owner_q == OWN_DAT);
                owner_d  = OWN_NONE;
            end
            default: ;
        endcase
    end

    // State and output registers; async reset leaves everything quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            lg_dat_q    <= 1'b1;
            addr_q      <= '0;
            len_q       <= '0;
            breq_q      <= 1'b0;
            wd_q        <= '0;
            isa_data_q  <= '0;
            isa_valid_q <= 1'b0;
            isa_cnt_q   <= '0;
            isa_done_q  <= 1'b0;
            dat_data_q  <= '0;
            dat_valid_q <= 1'b0;
            dat_cnt_q   <= '0;
            dat_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lg_dat_q    <= lg_dat_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            breq_q      <= breq_d;
            wd_q        <= wd_d;
            isa_data_q  <= isa_data_d;
            isa_valid_q <= isa_valid_d;
            isa_cnt_q   <= isa_cnt_d;
            isa_done_q  <= isa_done_d;
            dat_data_q  <= dat_data_d;
            dat_valid_q <= dat_valid_d;
            dat_cnt_q   <= dat_cnt_d;
            dat_done_q  <= dat_done_d;
            err_q       <= err_d;
        end
    end

    assign isa_rd_data   = isa_data_q;
    assign isa_rd_valid  = isa_valid_q;
    assign isa_rd_cnt    = isa_cnt_q;
    assign isa_rd_done   = isa_done_q;
    assign dat_rd_data   = dat_data_q;
    assign dat_rd_valid  = dat_valid_q;
    assign dat_rd_cnt    = dat_cnt_q;
    assign dat_rd_done   = dat_done_q;
    assign rd_burst_req  = breq_q;
    assign rd_burst_addr = addr_q;
    assign rd_burst_len  = len_q;
    assign rd_err        = err_q;
    assign owner         = owner_q;
    assign st_cur_arb    = state_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed scenarios against a transaction-level model of
// the arbiter, compared every cycle, plus literal expectations per scenario.
module tb_ddr_rd_arbiter;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int IW = 30;
    localparam int LW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          isa_rd_req = 1'b0;
    logic [AW-1:0] isa_rd_addr = '0;
    logic [LW-1:0] isa_rd_len = '0;
    logic [IW-1:0] isa_rd_data;
    logic          isa_rd_valid;
    logic [LW-1:0] isa_rd_cnt;
    logic          isa_rd_done;
    logic          dat_rd_req = 1'b0;
    logic [AW-1:0] dat_rd_addr = '0;
    logic [LW-1:0] dat_rd_len = '0;
    logic [DW-1:0] dat_rd_data;
    logic          dat_rd_valid;
    logic [LW-1:0] dat_rd_cnt;
    logic          dat_rd_done;
    logic          rd_burst_req;
    logic [AW-1:0] rd_burst_addr;
    logic [LW-1:0] rd_burst_len;
    logic [DW-1:0] rd_burst_data = '0;
    logic          rd_burst_data_valid = 1'b0;
    logic          rd_burst_finish = 1'b0;
    logic          rd_err;
    logic [1:0]    owner;
    logic [1:0]    st_cur_arb;

    int n_vec = 0;
    int n_bad = 0;

    ddr_rd_arbiter #(
        .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .ISA_WIDTH(IW),
        .LEN_WIDTH(LW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .isa_rd_req(isa_rd_req), .isa_rd_addr(isa_rd_addr), .isa_rd_len(isa_rd_len),
        .isa_rd_data(isa_rd_data), .isa_rd_valid(isa_rd_valid),
        .isa_rd_cnt(isa_rd_cnt), .isa_rd_done(isa_rd_done),
        .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_len(dat_rd_len),
        .dat_rd_data(dat_rd_data), .dat_rd_valid(dat_rd_valid),
        .dat_rd_cnt(dat_rd_cnt), .dat_rd_done(dat_rd_done),
        .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr),
        .rd_burst_len(rd_burst_len), .rd_burst_data(rd_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
        .rd_err(rd_err), .owner(owner), .st_cur_arb(st_cur_arb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Tracks the burst in flight by its owner, whether DDR has been asked yet,
    // the cycles since the last sign of life, and a one-cycle wrap-up after it ends.
    logic          e_req = 0, e_isa_valid = 0, e_dat_valid = 0;
    logic          e_isa_done = 0, e_dat_done = 0, e_err = 0;
    logic [1:0]    e_owner = 0;
    logic [AW-1:0] e_addr = 0;
    logic [LW-1:0] e_len = 0, e_isa_cnt = 0, e_dat_cnt = 0;
    logic [IW-1:0] e_isa_data = 0;
    logic [DW-1:0] e_dat_data = 0;
    bit            m_busy = 0, m_asked = 0, m_wrap = 0, m_lg_dat = 1;
    int            m_quiet = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            e_req = 0; e_isa_valid = 0; e_dat_valid = 0; e_isa_done = 0;
            e_dat_done = 0; e_err = 0; e_owner = 0; e_addr = 0; e_len = 0;
            e_isa_cnt = 0; e_dat_cnt = 0; e_isa_data = 0; e_dat_data = 0;
            m_busy = 0; m_asked = 0; m_wrap = 0; m_lg_dat = 1; m_quiet = 0;
        end else begin
            bit beat, ended;
            logic [LW-1:0] got;
            e_isa_valid = 0; e_dat_valid = 0; e_isa_done = 0; e_dat_done = 0; e_err = 0;
            if (m_wrap) begin
                m_wrap = 0;
                m_lg_dat = (e_owner == 2'b10);
                e_owner = 0;
            end else if (!m_busy) begin
                if (isa_rd_req || dat_rd_req) begin
                    bit to_isa;
                    to_isa  = isa_rd_req && (!dat_rd_req || m_lg_dat);
                    e_owner = to_isa ? 2'b01 : 2'b10;
                    e_addr  = to_isa ? isa_rd_addr : dat_rd_addr;
                    e_len   = to_isa ? isa_rd_len : dat_rd_len;
                    if (to_isa) e_isa_cnt = 0; else e_dat_cnt = 0;
                    m_quiet = 0;
                    if (e_len == 0) begin
                        m_wrap = 1;
                        e_isa_done = to_isa;
                        e_dat_done = !to_isa;
                    end else begin
                        m_busy = 1;
                        m_asked = 0;
                    end
                end
            end else if (!m_asked) begin
                m_asked = 1;
                m_quiet++;
                e_req = 1;
            end else begin
                beat = rd_burst_data_valid;
                if (beat) begin
                    m_quiet = 0;
                    if (e_owner == 2'b01) begin
                        e_isa_data = rd_burst_data[IW-1:0];
                        e_isa_valid = 1;
                        e_isa_cnt++;
                    end else begin
                        e_dat_data = rd_burst_data;
                        e_dat_valid = 1;
                        e_dat_cnt++;
                    end
                end else begin
                    m_quiet++;
                end
                got = (e_owner == 2'b01) ? e_isa_cnt : e_dat_cnt;
                ended = (beat && got == e_len) || rd_burst_finish || m_quiet == TO;
                if (ended) begin
                    e_req = 0;
                    m_busy = 0;
                    m_wrap = 1;
                    e_isa_done = (e_owner == 2'b01);
                    e_dat_done = (e_owner == 2'b10);
                    e_err = !beat && !rd_burst_finish;
                end
            end
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        chk("rd_burst_req", rd_burst_req, e_req);
        chk("rd_burst_addr", rd_burst_addr, e_addr);
        chk("rd_burst_len", rd_burst_len, e_len);
        chk("owner", owner, e_owner);
        chk("isa_rd_valid", isa_rd_valid, e_isa_valid);
        chk("isa_rd_cnt", isa_rd_cnt, e_isa_cnt);
        chk("isa_rd_done", isa_rd_done, e_isa_done);
        chk("dat_rd_valid", dat_rd_valid, e_dat_valid);
        chk("dat_rd_cnt", dat_rd_cnt, e_dat_cnt);
        chk("dat_rd_done", dat_rd_done, e_dat_done);
        chk("rd_err", rd_err, e_err);
        if (e_isa_valid) chk("isa_rd_data", isa_rd_data, e_isa_data);
        if (e_dat_valid) chk("dat_rd_data", dat_rd_data, e_dat_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!rd_burst_req && n < 50) begin tick(); n++; end
        chk("wait_rd_burst_req", rd_burst_req, 1'b1);
    endtask

    task automatic beats(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data = base + DW'(i);
            tick();
        end
        rd_burst_data_valid = 1'b0;
    endtask

    task automatic wait_done(input bit isa, output int n);
        n = 0;
        while (!(isa ? isa_rd_done : dat_rd_done) && n < 60) begin tick(); n++; end
        chk(isa ? "wait_isa_done" : "wait_dat_done", isa ? isa_rd_done : dat_rd_done, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tick();
        // Reset state pinned literally.
        chk("reset_owner", owner, 2'b00);
        chk("reset_req", rd_burst_req, 1'b0);
        chk("reset_state", st_cur_arb, 2'd0);
        rst = 1'b1;
        tick();

        // ISA only, len 4, four consecutive beats.
        isa_rd_addr = 28'h0100; isa_rd_len = 4; isa_rd_req = 1;
        tick();
        chk("isa_owner", owner, 2'b01);
        chk("isa_addr", rd_burst_addr, 28'h0100);
        wait_req();
        beats(4, 32'hC000_0010);
        chk("isa_done_after_4", isa_rd_done, 1'b1);
        chk("isa_cnt_4", isa_rd_cnt, 10'd4);
        chk("isa_last_data", isa_rd_data, 30'h0000_0013);
        isa_rd_req = 0;
        tick(); tick(); tick();

        // Contention straight after reset: ISA, then data, then ISA.
        do_reset();
        isa_rd_addr = 28'h0200; isa_rd_len = 2;
        dat_rd_addr = 28'h0300; dat_rd_len = 2;
        isa_rd_req = 1; dat_rd_req = 1;
        tick();
        chk("rr_first_isa", owner, 2'b01);
        wait_req();
        beats(2, 32'h11);
        wait_done(1, n);
        tick(); tick();
        chk("rr_then_dat", owner, 2'b10);
        chk("rr_dat_addr", rd_burst_addr, 28'h0300);
        wait_req();
        beats(2, 32'hABCD_0000);
        wait_done(0, n);
        chk("dat_cnt_2", dat_rd_cnt, 10'd2);
        tick(); tick();
        chk("rr_isa_again", owner, 2'b01);
        wait_req();
        beats(2, 32'h21);
        wait_done(1, n);
        isa_rd_req = 0; dat_rd_req = 0;
        tick(); tick();

        // Data len 8, finish after 5 beats; requester drops req mid-burst.
        dat_rd_addr = 28'h0400; dat_rd_len = 8; dat_rd_req = 1;
        wait_req();
        beats(2, 32'h5000);
        dat_rd_req = 0;
        beats(3, 32'h6000);
        rd_burst_finish = 1;
        tick();
        rd_burst_finish = 0;
        chk("fin_dat_done", dat_rd_done, 1'b1);
        chk("fin_dat_cnt", dat_rd_cnt, 10'd5);
        chk("fin_no_err", rd_err, 1'b0);
        tick(); tick();

        // ISA len 3, one beat then silence: watchdog abort.
        isa_rd_addr = 28'h0500; isa_rd_len = 3; isa_rd_req = 1;
        wait_req();
        beats(1, 32'h77);
        n = 0;
        while (!isa_rd_done && n < 40) begin tick(); n++; end
        chk("wd_latency", 64'(n), 64'd16);
        chk("wd_err", rd_err, 1'b1);
        chk("wd_cnt", isa_rd_cnt, 10'd1);
        isa_rd_req = 0;
        tick(); tick();

        // Data burst that never sees a beat.
        dat_rd_addr = 28'h0600; dat_rd_len = 2; dat_rd_req = 1;
        wait_done(0, n);
        chk("wd_first_beat_err", rd_err, 1'b1);
        dat_rd_req = 0;
        tick(); tick();

        // Stray beat while idle is dropped.
        beats(1, 32'hDEAD);
        tick();

        // Reset mid-burst after 2 of 6 beats; held request is regranted.
        isa_rd_addr = 28'h0700; isa_rd_len = 6; isa_rd_req = 1;
        wait_req();
        beats(2, 32'h900);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_req", rd_burst_req, 1'b0);
        chk("rst_mid_owner", owner, 2'b00);
        chk("rst_mid_cnt", isa_rd_cnt, 10'd0);
        chk("rst_mid_addr", rd_burst_addr, 28'h0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("regrant_owner", owner, 2'b01);
        chk("regrant_cnt", isa_rd_cnt, 10'd0);
        wait_req();
        beats(6, 32'hA00);
        wait_done(1, n);
        chk("regrant_cnt_6", isa_rd_cnt, 10'd6);
        isa_rd_req = 0;
        tick(); tick();

        // Zero-length data request: done without touching DDR.
        dat_rd_addr = 28'h0800; dat_rd_len = 0; dat_rd_req = 1;
        n = 0;
        while (!dat_rd_done && n < 10) begin tick(); n++; end
        chk("zlen_latency_le2", 64'(n <= 2), 64'd1);
        chk("zlen_cnt", dat_rd_cnt, 10'd0);
        chk("zlen_no_req", rd_burst_req, 1'b0);
        dat_rd_req = 0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Shares the single DDR read-burst channel between the instruction cache (ISA fetch) and the data path (LOADRBR/LOADCBC operand fetch). It accepts level-held burst requests from both requesters and grants them round-robin, one complete burst at a time. It drives the DDR interface's burst-request port and steers returned beats, with a per-requester beat count, back to the current owner. A watchdog aborts bursts that stall.

## Interface
Parameters:
- DDR_ADDR_WIDTH, 28, DDR byte-address width
- DDR_DATA_WIDTH, 32, DDR read-beat width
- ISA_WIDTH, 30, instruction width; ISA data = low ISA_WIDTH bits of beat
- LEN_WIDTH, 10, burst length / beat counter width
- TIMEOUT, 1024, max cycles between beats (or grant to first beat) before abort

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- isa_rd_req  in  1  ISA burst request, level, held until isa_rd_done
- isa_rd_addr  in  DDR_ADDR_WIDTH  ISA burst start address
- isa_rd_len  in  LEN_WIDTH  ISA burst length in beats
- isa_rd_data  out  ISA_WIDTH  ISA beat data
- isa_rd_valid  out  1  ISA beat strobe
- isa_rd_cnt  out  LEN_WIDTH  beats delivered to ISA in current burst
- isa_rd_done  out  1  one-cycle pulse: ISA burst ended
- dat_rd_req / dat_rd_addr / dat_rd_len  in  1 / DDR_ADDR_WIDTH / LEN_WIDTH  data-side equivalents
- dat_rd_data  out  DDR_DATA_WIDTH  data beat
- dat_rd_valid / dat_rd_cnt / dat_rd_done  out  1 / LEN_WIDTH / 1  data-side equivalents
- rd_burst_req  out  1  to DDR interface, held for whole burst
- rd_burst_addr  out  DDR_ADDR_WIDTH  latched start address
- rd_burst_len  out  LEN_WIDTH  latched length
- rd_burst_data  in  DDR_DATA_WIDTH  beat from DDR
- rd_burst_data_valid  in  1  beat strobe
- rd_burst_finish  in  1  DDR burst-complete pulse
- rd_err  out  1  one-cycle pulse with done when burst aborted by watchdog
- owner  out  2  01 = ISA, 10 = data, 00 = none
- st_cur_arb  out  2  current state, for debug

## Operation
- States: IDLE=0, GRANT=1, BURST=2, DONE=3.
- IDLE: if any request, choose winner. Both asserted: grant the requester not in last_grant. last_grant resets to data, so ISA wins first contention. Latch addr/len into rd_burst_addr/len, set owner, clear owner cnt, go GRANT.
- Zero length (len==0): no DDR request; go DONE directly (done pulse, cnt=0).
- GRANT: assert rd_burst_req; go BURST next cycle.
- BURST: rd_burst_req stays 1. Each cycle with rd_burst_data_valid=1: register beat to owner's data, pulse owner's valid, owner cnt += 1. Non-owner valid never asserted.
- Leave BURST for DONE when cnt reaches len (counting the current beat), or rd_burst_finish=1, or the watchdog expires. If these coincide, watchdog is lowest priority: no rd_err when a beat or finish occurs in the same cycle.
- Watchdog: counter cleared on entering GRANT and on every beat. Reaching TIMEOUT sets the abort.
- DONE: rd_burst_req=0; pulse owner's done, plus rd_err if aborted. last_grant <= owner; owner <= 00; go IDLE.
- Beats arriving outside BURST are dropped.
- A requester dropping req mid-burst does not shorten the burst. The burst still runs to completion and the done pulse is still issued.
- A request held after its done pulse is re-arbitrated as a new burst.

## Timing
- Reset (async, any state including mid-burst): state IDLE. All outputs 0: rd_burst_req, addr, len, data, valid, cnt, done, rd_err, owner. last_grant = data. Watchdog = 0.
- Request seen in IDLE at edge N: owner/addr/len valid after N; rd_burst_req high after N+1.
- Beat at edge M: owner data/valid/cnt updated after M (1-cycle latency). Valid is high exactly one cycle per beat.
- Last beat at edge M: DONE after M, with done pulse and rd_burst_req low. IDLE after M+1; the earliest next grant registers at M+2.
- Back-to-back bursts: minimum 3 idle cycles on rd_burst_req between bursts.
- cnt holds its final value after done until the next grant to that requester.

## Test plan
- ISA only, len=4, beats on 4 consecutive cycles -> isa_rd_valid ×4, isa_rd_cnt 1..4, isa_rd_done one cycle after 4th beat; dat_rd_valid never high.
- Both requests same cycle after reset -> ISA granted first (owner=01). After its done, data granted (owner=10); then ISA again if both still requesting.
- Data len=8, rd_burst_finish after 5 beats -> dat_rd_done next cycle, dat_rd_cnt=5, rd_err=0.
- ISA len=3, beats stop after 1, TIMEOUT=16 -> isa_rd_done and rd_err pulse together 16 cycles after the last beat; cnt=1.
- Reset asserted mid-burst (2 of 6 beats delivered) -> rd_burst_req and all outputs 0 immediately; after release, the held request is regranted with cnt starting at 0.
- dat_rd_len=0 -> dat_rd_done within 2 cycles; rd_burst_req never asserted.
